// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the two-requester memory read arbiter.
// Requester IDs double as the round-robin "last grant" encoding.
package mem_arb_pkg;

    localparam int ADDR_W = 61;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    typedef logic req_id_t;

    localparam req_id_t REQ_FETCH = 1'b0;
    localparam req_id_t REQ_LOAD  = 1'b1;

    typedef enum logic {
        IDLE,
        WAIT
    } arb_state_t;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Bundle of the fetch/load request-response channels and the memory read port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_read_arbiter_if;

    logic                               f_req_valid;
    logic                               f_req_ready;
    logic [0:mem_arb_pkg::ADDR_W-1]     f_req_addr;
    logic                               f_rsp_valid;
    logic [0:mem_arb_pkg::DATA_W-1]     f_rsp_data;

    logic                               l_req_valid;
    logic                               l_req_ready;
    logic [0:mem_arb_pkg::ADDR_W-1]     l_req_addr;
    logic                               l_rsp_valid;
    logic [0:mem_arb_pkg::DATA_W-1]     l_rsp_data;

    logic [0:mem_arb_pkg::ADDR_W-1]     mem_addr;
    logic [0:mem_arb_pkg::DATA_W-1]     mem_rdata;
    logic                               busy;

    modport slave (
        input  f_req_valid, f_req_addr, l_req_valid, l_req_addr, mem_rdata,
        output f_req_ready, f_rsp_valid, f_rsp_data,
        output l_req_ready, l_rsp_valid, l_rsp_data,
        output mem_addr, busy
    );

    modport master (
        output f_req_valid, f_req_addr, l_req_valid, l_req_addr, mem_rdata,
        input  f_req_ready, f_rsp_valid, f_rsp_data,
        input  l_req_ready, l_rsp_valid, l_rsp_data,
        input  mem_addr, busy
    );

endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency doubleword read port between
// instruction fetch and load, with a single outstanding access.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_read_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    arb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [0:ADDR_W-1]   addr_q, addr_d;
    req_id_t             owner_q, owner_d;
    req_id_t             last_grant_q, last_grant_d;
    logic                f_rsp_valid_q, f_rsp_valid_d;
    logic                l_rsp_valid_q, l_rsp_valid_d;
    logic [0:DATA_W-1]   f_rsp_data_q, f_rsp_data_d;
    logic [0:DATA_W-1]   l_rsp_data_q, l_rsp_data_d;

    req_id_t             grant;
    logic                any_valid;
    logic                f_ready;
    logic                l_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            owner_q       <= REQ_FETCH;
            last_grant_q  <= REQ_LOAD;
            f_rsp_valid_q <= 1'b0;
            l_rsp_valid_q <= 1'b0;
            f_rsp_data_q  <= '0;
            l_rsp_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            f_rsp_valid_q <= f_rsp_valid_d;
            l_rsp_valid_q <= l_rsp_valid_d;
            f_rsp_data_q  <= f_rsp_data_d;
            l_rsp_data_q  <= l_rsp_data_d;
        end
    end

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        any_valid = bus.f_req_valid | bus.l_req_valid;
        grant     = REQ_FETCH;
        if (bus.f_req_valid && bus.l_req_valid) begin
            grant = (last_grant_q == REQ_FETCH) ? REQ_LOAD : REQ_FETCH;
        end else if (bus.l_req_valid) begin
            grant = REQ_LOAD;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        f_rsp_valid_d = 1'b0;
        l_rsp_valid_d = 1'b0;
        f_rsp_data_d  = f_rsp_data_q;
        l_rsp_data_d  = l_rsp_data_q;
        f_ready       = 1'b0;
        l_ready       = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    f_ready      = (grant == REQ_FETCH);
                    l_ready      = (grant == REQ_LOAD);
                    addr_d       = (grant == REQ_LOAD) ? bus.l_req_addr : bus.f_req_addr;
                    owner_d      = grant;
                    last_grant_d = grant;
                    cnt_d        = CNT_INIT;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (owner_q == REQ_LOAD) begin
                        l_rsp_valid_d = 1'b1;
                        l_rsp_data_d  = bus.mem_rdata;
                    end else begin
                        f_rsp_valid_d = 1'b1;
                        f_rsp_data_d  = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.f_req_ready = f_ready;
    assign bus.l_req_ready = l_ready;
    assign bus.f_rsp_valid = f_rsp_valid_q;
    assign bus.l_rsp_valid = l_rsp_valid_q;
    assign bus.f_rsp_data  = f_rsp_data_q;
    assign bus.l_rsp_data  = l_rsp_data_q;
    assign bus.mem_addr    = addr_q;
    assign bus.busy        = (state_q == WAIT);

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares one 64-bit doubleword read port of the unified memory between the instruction-fetch requester and the load requester of the PPC core. It sits between the core and `mem`, replacing the dual-port arrangement. Each requester uses a valid/ready request handshake and gets a one-cycle response pulse. Arbitration is round-robin with one outstanding access and a fixed memory latency.

## Interface
- `LATENCY`, default 1: cycles from address presentation to `mem_rdata` being sampled; legal range 1..15.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `f_req_valid`  in  1  fetch request valid.
- `f_req_ready`  out  1  fetch request accepted this cycle when high with `f_req_valid`.
- `f_req_addr`  in  [0:60]  fetch doubleword address.
- `f_rsp_valid`  out  1  fetch response pulse.
- `f_rsp_data`  out  [0:63]  fetch doubleword.
- `l_req_valid`, `l_req_ready`, `l_req_addr`, `l_rsp_valid`, `l_rsp_data`: same as fetch, for the load requester.
- `mem_addr`  out  [0:60]  address to memory read port.
- `mem_rdata`  in  [0:63]  memory read data.
- `busy`  out  1  high while an access is outstanding (state WAIT).

## Operation
- FSM states: IDLE, WAIT. Reset state IDLE.
- In IDLE, if any `*_req_valid` is high, grant exactly one requester:
  - If only one is valid, grant it.
  - If both are valid, grant the one not granted last (`last_grant` register).
- `*_req_ready` is combinational and high only in IDLE, and only for the granted requester. It is never high in WAIT.
- On acceptance:
  - Capture the address into `addr_q`, the granted ID into `owner_q` and `last_grant`.
  - Load `cnt` with LATENCY-1 and go to WAIT.
- WAIT: `cnt` decrements each cycle. When `cnt`==0:
  - Register `mem_rdata` into the owner's `*_rsp_data`.
  - Set the owner's `*_rsp_valid` for the next cycle.
  - Return to IDLE.
- `mem_addr` = `addr_q` at all times; it holds the last address in IDLE.
- There is no response backpressure; requesters must take `*_rsp_valid` pulses.
- `*_rsp_data` holds its value until the next response to that requester.
- Requester addresses need only be stable in the acceptance cycle.
- Doubleword addressing uses bit 0 as MSB. Word selection within the doubleword stays in the requester.
- Reset mid-WAIT: the access is abandoned and no response is issued.
- Reset values:
  - State IDLE, `cnt` 0.
  - `addr_q`/`mem_addr` 0, `owner_q` fetch.
  - `last_grant` load, so fetch wins the first tie.
  - Both `*_rsp_valid` 0, both `*_rsp_data` 0, `busy` 0.

## Timing
- Request accepted in cycle T. `mem_addr` shows it from T+1 through T+LATENCY.
- `mem_rdata` is sampled at the end of T+LATENCY.
- `*_rsp_valid` is high in T+LATENCY+1 only.
- The FSM is in IDLE in T+LATENCY+1, so a new request may be accepted in the same cycle a response pulses.
- Peak throughput is one access per LATENCY+1 cycles.
- Under continuous dual contention, grants strictly alternate fetch, load, fetch, …
- `busy` is high in T+1 through T+LATENCY.
- A requester dropping valid while not granted has no effect; no request is queued.

## Structure
- Shared package `mem_arb_pkg` holds:
  - `ADDR_W`=61 and `DATA_W`=64.
  - Requester IDs `REQ_FETCH`=0 and `REQ_LOAD`=1.
  - State enum `arb_state_t` {IDLE, WAIT}.
- `cnt` width is 4 bits (covers LATENCY up to 15).
- No sub-module is needed; the two-way round-robin pick is inline logic.

## Test plan
- Reset with both valids high, LATENCY=1 → `f_req_ready`=1 in the first IDLE cycle. `mem_addr`=fetch addr next cycle. `f_rsp_valid` pulses 2 cycles after accept with `mem_rdata`; `l_*` stays quiet.
- Both valid continuously, fetch addr 0x10 and load addr 0x20, LATENCY=3 → grants alternate F, L, F, L with accepts every 4 cycles. Each rsp pulse routes the data for its own address to the right port.
- Load only, LATENCY=2, `l_req_addr`=0x1FFF_FFFF_FFFF_FFFF (all ones) → `mem_addr` all ones for 2 cycles. `l_rsp_valid` at T+3, `busy` high exactly at T+1..T+2.
- Back-to-back fetch, LATENCY=1 → accept at T, rsp at T+2, second accept also at T+2 (same cycle as rsp), second rsp at T+4.
- Assert `rst_n` low during WAIT → `busy`, `*_rsp_valid` and `mem_addr` go to 0 immediately. No response after release, and the first tie goes to fetch.
- `f_req_valid` pulsed for one cycle while busy → never granted, never responded.
